addr_decoder: RTL and testbench

Receive-side counterpart of the address encoder: accepts a stream of 12-bit Gray-coded addresses and returns the binary addresses through a 2-stage registered pipeline with valid/ready flow control. It also checks that each accepted code differs from the previous one in exactly one bit. Violations are flagged per word and counted. It sits between the encoded address bus and the address consumer.

---
 rtl/addr_pkg.sv | 24 ++
 rtl/addr_seq_checker.sv | 50 +++++
 rtl/addr_decoder.sv | 110 +++++++++++
 tb/tb_addr_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_pkg.sv
// Shared address-bus definitions: width, Gray/binary helpers and checker states.
// Used by both the address encoder and the receive-side decoder.
package addr_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic {
    CHK_IDLE,
    CHK_TRACK
  } chk_state_e;

  function automatic logic [ADDR_W-1:0] bin2gray(input logic [ADDR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W-1:0] gray2bin(input logic [ADDR_W-1:0] g);
    logic [ADDR_W-1:0] b;
    for (int i = 0; i < ADDR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/addr_seq_checker.sv
// One-bit-step checker: holds the last accepted code and flags the current accept combinationally.
// No latency on the flag; reference and state update at the accepting edge, no backpressure of its own.
module addr_seq_checker
  import addr_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         acc_i,
  input  logic         resync_i,
  input  logic [W-1:0] code_i,
  output logic         flag_o
);

  chk_state_e   state_q, state_d;
  logic [W-1:0] ref_q, ref_d;
  logic [W-1:0] diff;
  logic         step_ok;

  assign diff    = code_i ^ ref_q;
  assign step_ok = (diff != '0) && ((diff & (diff - W'(1))) == '0);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    flag_o  = 1'b0;
    if (acc_i) begin
      // A resync coinciding with an accept makes this word the fresh, unchecked reference.
      ref_d   = code_i;
      state_d = CHK_TRACK;
      if (state_q == CHK_TRACK && !resync_i) begin
        flag_o = !step_ok;
      end
    end else if (resync_i) begin
      state_d = CHK_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHK_IDLE;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
    end
  end

endmodule

// File: rtl/addr_decoder.sv
// Gray-to-binary address decoder with sequence checking and a saturating error count.
// Two-cycle latency; valid/ready with in_ready combinational from out_ready, two words of buffering.
module addr_decoder
  import addr_pkg::*;
#(
  parameter int W     = ADDR_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in,
  output logic             in_ready,
  input  logic             resync,
  output logic             out_valid,
  output logic [W-1:0]     out,
  input  logic             out_ready,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_vld_q, s1_vld_d;
  logic [W-1:0]     s1_code_q, s1_code_d;
  logic             s1_err_q, s1_err_d;
  logic             out_vld_q, out_vld_d;
  logic [W-1:0]     out_q, out_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]     s1_bin;
  logic             adv;
  logic             acc;
  logic             chk_flag;

  assign adv      = !out_vld_q | out_ready;
  assign in_ready = !s1_vld_q | adv;
  assign acc      = in_valid & in_ready;

  addr_seq_checker #(.W(W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (acc),
    .resync_i (resync),
    .code_i   (in),
    .flag_o   (chk_flag)
  );

  always_comb begin
    s1_bin = '0;
    for (int i = 0; i < W; i++) begin
      s1_bin[i] = ^(s1_code_q >> i);
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_code_d = s1_code_q;
    s1_err_d  = s1_err_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;

    if (acc) begin
      s1_vld_d  = 1'b1;
      s1_code_d = in;
      s1_err_d  = chk_flag;
    end else if (adv) begin
      s1_vld_d  = 1'b0;
    end

    if (adv) begin
      out_vld_d = s1_vld_q;
      out_err_d = s1_vld_q & s1_err_q;
      if (s1_vld_q) begin
        out_d = s1_bin;
      end
    end

    // Counts delivered flagged words only, so a stalled word is counted once.
    if (out_vld_q && out_ready && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
      s1_err_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_code_q <= s1_code_d;
      s1_err_q  <= s1_err_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out       = out_q;
  assign seq_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_addr_decoder.sv
// Directed bench for addr_decoder: scoreboarded streams, stall patterns, error counting and reset.
module tb_addr_decoder;
  import addr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] din;
  logic        in_ready;
  logic        resync;
  logic        out_valid;
  logic [11:0] dout;
  logic        out_ready;
  logic        seq_err;
  logic [7:0]  err_cnt;

  addr_decoder #(.W(12), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (din),
    .in_ready  (in_ready),
    .resync    (resync),
    .out_valid (out_valid),
    .out       (dout),
    .out_ready (out_ready),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [11:0] o;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [11:0] drv_o;
  logic        drv_e;
  logic        rand_rdy;
  logic        hold_rdy;
  logic        lat_chk;
  logic        saw_stall;
  int          cyc;
  int          n_chk;
  int          n_pass;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
    end
  end

  // Scoreboard: at each negedge check what will happen at the next edge, then update.
  initial begin
    logic del, acc;
    exp_t ent;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (!in_ready) saw_stall = 1'b1;
        chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
        if (exp_q.size() == 0) chk("ovld_empty", out_valid, 0);
        if (out_valid && exp_q.size() > 0) begin
          chk("out", dout, exp_q[0].o);
          chk("seq_err", seq_err, exp_q[0].e);
          if (lat_chk) chk("latency", cyc - acc_q[0], 2);
        end else if (!out_valid) begin
          chk("err_idle", seq_err, 0);
        end
        del   = out_valid && out_ready && exp_q.size() > 0;
        acc   = in_valid && in_ready;
        ent.o = drv_o;
        ent.e = drv_e;
        @(posedge clk);
        if (del) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        if (acc) begin
          exp_q.push_back(ent);
          acc_q.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [11:0] code, input logic [11:0] eo, input logic ee,
                      input logic rs);
    bit ok;
    in_valid = 1'b1;
    din      = code;
    resync   = rs;
    drv_o    = eo;
    drv_e    = ee;
    ok       = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    resync = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    resync   = 1'b0;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b1; in_valid = 1'b0; din = '0; resync = 1'b0;
    drv_o = '0; drv_e = 1'b0;
    rand_rdy = 1'b0; hold_rdy = 1'b1; lat_chk = 1'b0; saw_stall = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", dout, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full Gray sweep plus the 0x800 -> 0x000 wrap, back to back.
    lat_chk = 1'b1;
    for (int i = 0; i < 4096; i++) send(bin2gray(12'(i)), 12'(i), 1'b0, 1'b0);
    send(12'h000, 12'h000, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;
    chk("cnt_sweep", err_cnt, 0);

    // Same sweep with a randomly stalling consumer.
    rand_rdy  = 1'b1;
    saw_stall = 1'b0;
    for (int i = 0; i < 4096; i++) send(bin2gray(12'(i)), 12'(i), 1'b0, i == 0);
    send(12'h000, 12'h000, 1'b0, 1'b0);
    drain();
    rand_rdy = 1'b0;
    chk("stall_seen", saw_stall, 1);
    chk("cnt_stall", err_cnt, 0);

    // Two-bit step then a repeat.
    send(12'h000, 12'h000, 1'b0, 1'b1);
    send(12'h003, 12'h002, 1'b1, 1'b0);
    send(12'h003, 12'h002, 1'b1, 1'b0);
    drain();
    chk("cnt_steps", err_cnt, 2);

    // Resync on a multi-bit jump, then a checked legal step.
    send(12'h000, 12'h000, 1'b0, 1'b1);
    send(12'h0F0, 12'h0A0, 1'b0, 1'b1);
    send(12'h0F1, 12'h0A1, 1'b0, 1'b0);
    drain();
    chk("cnt_resync", err_cnt, 2);

    // Saturation: 2 + 299 errors clamps at 255, and stays there.
    send(12'h005, 12'h006, 1'b0, 1'b1);
    for (int i = 0; i < 299; i++) send(12'h005, 12'h006, 1'b1, 1'b0);
    drain();
    chk("cnt_sat", err_cnt, 255);
    for (int i = 0; i < 3; i++) send(12'h005, 12'h006, 1'b1, 1'b0);
    drain();
    chk("cnt_sat_hold", err_cnt, 255);

    // Reset with both stages full: words dropped, first word after is unchecked.
    hold_rdy = 1'b0;
    @(posedge clk);
    #1;
    send(12'h001, 12'h001, 1'b0, 1'b0);
    send(12'h003, 12'h002, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("full_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_seq_err", seq_err, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(12'h7FF, 12'h555, 1'b0, 1'b0);
    drain();
    chk("cnt_after_rst", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
